// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Request/write-stage bundle, requester indices, register-file geometry.
package rf_pkg;

  localparam int RF_DW   = 8;
  localparam int RF_AW   = 3;
  localparam int RF_NREG = 8;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports: req[1:0], hold, last_grant in; one-hot gnt[1:0] out.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       hold,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (hold) begin
      gnt = 2'b00;
    end else if (req == 2'b11) begin
      // contended: the port that did not win last time goes now
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file's single write port.
// Ports: req_* handshake (ALU=0, MEM=1), wr_hold, rf_* write pins,
// rs_addr/rf_out_rs/rs_data bypass path, contention_cnt.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [1:0][AW-1:0]  req_rd,
  input  logic [1:0][DW-1:0]  req_data,
  output logic [1:0]          req_ready,
  input  logic                wr_hold,
  output logic                rf_reg_write,
  output logic [AW-1:0]       rf_rd,
  output logic [DW-1:0]       rf_data_in,
  input  logic [AW-1:0]       rs_addr,
  input  logic [DW-1:0]       rf_out_rs,
  output logic [DW-1:0]       rs_data,
  output logic [CW-1:0]       contention_cnt
);

  logic [1:0] w_gnt;
  logic       w_xfer;
  rf_wr_t     w_sel;

  logic       r_we;
  rf_wr_t     r_wr;
  logic       r_last;
  logic [CW-1:0] r_cnt;

  rr_arb2 u_arb (
    .req        (req_valid),
    .hold       (wr_hold),
    .last_grant (r_last),
    .gnt        (w_gnt)
  );

  assign req_ready = w_gnt;
  assign w_xfer    = |w_gnt;

  always_comb begin
    w_sel.rd   = req_rd[REQ_ALU];
    w_sel.data = req_data[REQ_ALU];
    if (w_gnt[REQ_MEM]) begin
      w_sel.rd   = req_rd[REQ_MEM];
      w_sel.data = req_data[REQ_MEM];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we   <= 1'b0;
      r_wr   <= '0;
      r_last <= 1'b1;
    end else begin
      r_we <= w_xfer;
      if (w_xfer) begin
        r_wr   <= w_sel;
        r_last <= w_gnt[REQ_MEM];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (&req_valid && r_cnt != '1) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign rf_reg_write   = r_we;
  assign rf_rd          = r_wr.rd;
  assign rf_data_in     = r_wr.data;
  assign contention_cnt = r_cnt;

  assign rs_data = (r_we && r_wr.rd == rs_addr) ? r_wr.data : rf_out_rs;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter with a RegFile model
// and a queue of expected writes compared as they appear.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic            clk = 0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0][2:0] req_rd;
  logic [1:0][7:0] req_data;
  logic [1:0]      req_ready;
  logic            wr_hold;
  logic            rf_reg_write;
  logic [2:0]      rf_rd;
  logic [7:0]      rf_data_in;
  logic [2:0]      rs_addr;
  logic [7:0]      rf_out_rs;
  logic [7:0]      rs_data;
  logic [7:0]      contention_cnt;

  int errs = 0;
  int checks = 0;
  rf_wr_t exp_q[$];
  logic [7:0] regs [RF_NREG];

  rf_write_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready),
    .wr_hold(wr_hold), .rf_reg_write(rf_reg_write),
    .rf_rd(rf_rd), .rf_data_in(rf_data_in),
    .rs_addr(rs_addr), .rf_out_rs(rf_out_rs),
    .rs_data(rs_data), .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < RF_NREG; i++) regs[i] = 8'h00;
  always @(posedge clk) if (rf_reg_write) regs[rf_rd] <= rf_data_in;
  assign rf_out_rs = regs[rs_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && rf_reg_write) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", 1, 0);
      end else begin
        rf_wr_t e;
        e = exp_q.pop_front();
        chk("wr_rd", 32'(rf_rd), 32'(e.rd));
        chk("wr_data", 32'(rf_data_in), 32'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic rf_wr_t mk(input logic [2:0] rd,
                                input logic [7:0] d);
    rf_wr_t w;
    w.rd = rd;
    w.data = d;
    return w;
  endfunction

  initial begin
    reset = 0;
    req_valid = 2'b00;
    req_rd = '0;
    req_data = '0;
    wr_hold = 0;
    rs_addr = 0;
    step();
    chk("rst_we", 32'(rf_reg_write), 0);
    chk("rst_rd", 32'(rf_rd), 0);
    chk("rst_data", 32'(rf_data_in), 0);
    chk("rst_cnt", 32'(contention_cnt), 0);
    reset = 1;
    step();

    // ALU-only write R1=0x55
    req_valid = 2'b01; req_rd[0] = 3'd1; req_data[0] = 8'h55;
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    exp_q.push_back(mk(3'd1, 8'h55));
    step();
    req_valid = 2'b00;
    #1 chk("t1_we", 32'(rf_reg_write), 1);
    step();
    rs_addr = 3'd1;
    #1 chk("t1_r1", 32'(rs_data), 32'h55);

    // fresh reset so ALU wins the first contended cycle
    reset = 0;
    step();
    reset = 1;
    step();

    // contention, different rd
    req_valid = 2'b11;
    req_rd[0] = 3'd2; req_data[0] = 8'h11;
    req_rd[1] = 3'd3; req_data[1] = 8'h22;
    #1 chk("t2_ready_a", 32'(req_ready), 32'h1);
    exp_q.push_back(mk(3'd2, 8'h11));
    step();
    req_valid = 2'b10;
    #1 chk("t2_ready_m", 32'(req_ready), 32'h2);
    exp_q.push_back(mk(3'd3, 8'h22));
    step();
    req_valid = 2'b00;
    #1 chk("t2_cnt", 32'(contention_cnt), 1);
    step();

    // ALU-only write so last_grant becomes ALU
    req_valid = 2'b01; req_rd[0] = 3'd7; req_data[0] = 8'h77;
    #1 chk("t3_pre", 32'(req_ready), 32'h1);
    exp_q.push_back(mk(3'd7, 8'h77));
    step();
    // same rd from both ports
    req_valid = 2'b11;
    req_rd[0] = 3'd4; req_data[0] = 8'hAA;
    req_rd[1] = 3'd4; req_data[1] = 8'hBB;
    #1 chk("t3_ready_m", 32'(req_ready), 32'h2);
    exp_q.push_back(mk(3'd4, 8'hBB));
    step();
    req_valid = 2'b01;
    #1 chk("t3_ready_a", 32'(req_ready), 32'h1);
    exp_q.push_back(mk(3'd4, 8'hAA));
    step();
    req_valid = 2'b00;
    step();
    rs_addr = 3'd4;
    #1 chk("t3_r4", 32'(rs_data), 32'hAA);
    chk("t3_cnt", 32'(contention_cnt), 2);

    // bypass during the write cycle
    req_valid = 2'b01; req_rd[0] = 3'd5; req_data[0] = 8'h3C;
    exp_q.push_back(mk(3'd5, 8'h3C));
    step();
    req_valid = 2'b00;
    rs_addr = 3'd5;
    #1 chk("t4_old", 32'(rf_out_rs), 32'h00);
    chk("t4_byp", 32'(rs_data), 32'h3C);
    rs_addr = 3'd6;
    #1 chk("t4_nobyp", 32'(rs_data), 32'h00);
    step();
    rs_addr = 3'd5;
    #1 chk("t4_r5", 32'(rs_data), 32'h3C);
    chk("t4_we0", 32'(rf_reg_write), 0);

    // hold with MEM valid
    wr_hold = 1;
    req_valid = 2'b10; req_rd[1] = 3'd6; req_data[1] = 8'h99;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t5_hold_rdy", 32'(req_ready), 0);
      chk("t5_hold_we", 32'(rf_reg_write), 0);
      step();
    end
    wr_hold = 0;
    #1 chk("t5_rel", 32'(req_ready), 32'h2);
    exp_q.push_back(mk(3'd6, 8'h99));
    step();
    req_valid = 2'b00;
    step();

    // counter saturation while held
    wr_hold = 1;
    req_valid = 2'b11;
    for (int i = 0; i < 260; i++) step();
    chk("sat_cnt", 32'(contention_cnt), 32'hFF);
    req_valid = 2'b00;
    step();
    wr_hold = 0;

    // reset during a registered write
    req_valid = 2'b01; req_rd[0] = 3'd1; req_data[0] = 8'hEE;
    step();
    req_valid = 2'b00;
    chk("t6_we1", 32'(rf_reg_write), 1);
    reset = 0;
    #1 chk("t6_drop", 32'(rf_reg_write), 0);
    chk("t6_cnt", 32'(contention_cnt), 0);
    step();
    rs_addr = 3'd1;
    #1 chk("t6_r1", 32'(rs_data), 32'h55);
    reset = 1;
    step();
    step();

    chk("q_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
